// File: rtl/display_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_flip_ctrl
// Brief    : Double-buffer flip scheduler. Brings the display up on the first
//            vertical blank, acknowledges every VBLANK through the CLRVBLNK
//            handshake, and swaps DISPADDR between two frame buffers on
//            renderer request. Swaps happen only inside a blanking interval.
// Ports    : clk, rst (sync, active-low)
//            enable    - display should be on (sampled at VBLANK only)
//            VBLANK    - sticky blank flag from display IP
//            flip_req  - single-cycle swap request from the renderer
//            CLRVBLNK  - VBLANK clear request to display IP
//            DISPADDR  - current front-buffer word address
//            DISPON    - display enable
//            flip_ack  - one-cycle pulse when a swap is performed
//            back_addr - buffer the renderer may draw into
//            front_sel - 0 = FB0 displayed, 1 = FB1 displayed
//            frame_cnt - VBLANKs serviced since reset (wrapping)
//            clr_err   - sticky CLRVBLNK timeout flag
//            state     - FSM state, for debug
// Revision : 1.0 - initial release
// ============================================================================
module display_flip_ctrl #(
  parameter logic [29:0] FB0_ADDR    = 30'h1085557C,
  parameter logic [29:0] FB1_ADDR    = 30'h10426240,
  parameter logic [15:0] CLR_TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        VBLANK,
  input  logic        flip_req,
  output logic        CLRVBLNK,
  output logic [29:0] DISPADDR,
  output logic        DISPON,
  output logic        flip_ack,
  output logic [29:0] back_addr,
  output logic        front_sel,
  output logic [15:0] frame_cnt,
  output logic        clr_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_WAIT = 3'd1,
    S_CLR  = 3'd2,
    S_SHOW = 3'd3
  } state_t;

  state_t      r_state;
  logic        r_clr;
  logic [29:0] r_dispaddr;
  logic        r_dispon;
  logic        r_flip_ack;
  logic [29:0] r_back_addr;
  logic        r_front_sel;
  logic [15:0] r_frame_cnt;
  logic        r_clr_err;
  logic        r_pending;
  logic [15:0] r_clr_cnt;
  // A timeout exit leaves VBLANK still high; this flag blocks that same
  // assertion from being serviced again until VBLANK is seen low.
  logic        r_vb_armed;

  logic        w_vb_new;
  logic        w_flip;
  logic        w_swap;
  logic [29:0] w_front_addr;
  logic [29:0] w_other_addr;

  assign w_vb_new     = VBLANK & r_vb_armed;
  assign w_flip       = r_pending | flip_req;
  assign w_front_addr = r_front_sel ? FB1_ADDR : FB0_ADDR;
  assign w_other_addr = r_front_sel ? FB0_ADDR : FB1_ADDR;
  // A swap consumes the request; it can occur from S_SHOW, or from S_WAIT when
  // the display is being re-enabled with a request still outstanding.
  assign w_swap       = w_vb_new & enable & w_flip &
                        ((r_state == S_WAIT) | (r_state == S_SHOW));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RST;
      r_clr       <= 1'b1;
      r_dispaddr  <= 30'd0;
      r_dispon    <= 1'b0;
      r_flip_ack  <= 1'b0;
      r_back_addr <= FB1_ADDR;
      r_front_sel <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_clr_err   <= 1'b0;
      r_pending   <= 1'b0;
      r_clr_cnt   <= 16'd0;
      r_vb_armed  <= 1'b1;
    end else begin
      r_flip_ack <= 1'b0;
      if (!VBLANK) begin
        r_vb_armed <= 1'b1;
      end

      // Request capture: anything not consumed by a swap this cycle is held.
      if (r_state != S_RST) begin
        if (w_swap) begin
          r_pending <= 1'b0;
        end else if (flip_req) begin
          r_pending <= 1'b1;
        end
      end

      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
        r_dispaddr  <= w_other_addr;
        r_back_addr <= w_front_addr;
        r_flip_ack  <= 1'b1;
      end

      case (r_state)
        S_RST: begin
          r_clr   <= 1'b0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_vb_new) begin
            r_clr       <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_clr_cnt   <= 16'd0;
            r_state     <= S_CLR;
            if (enable) begin
              r_dispon <= 1'b1;
              if (!w_flip) begin
                r_dispaddr <= w_front_addr;
              end
            end
          end
        end

        S_CLR: begin
          if (!VBLANK) begin
            r_clr   <= 1'b0;
            r_state <= r_dispon ? S_SHOW : S_WAIT;
          end else if (r_clr_cnt == CLR_TIMEOUT - 16'd1) begin
            r_clr_err  <= 1'b1;
            r_clr      <= 1'b0;
            r_vb_armed <= 1'b0;
            r_state    <= r_dispon ? S_SHOW : S_WAIT;
          end else begin
            r_clr_cnt <= r_clr_cnt + 16'd1;
          end
        end

        S_SHOW: begin
          if (w_vb_new) begin
            r_clr       <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_clr_cnt   <= 16'd0;
            r_state     <= S_CLR;
            if (!enable) begin
              r_dispon <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

  assign CLRVBLNK  = r_clr;
  assign DISPADDR  = r_dispaddr;
  assign DISPON    = r_dispon;
  assign flip_ack  = r_flip_ack;
  assign back_addr = r_back_addr;
  assign front_sel = r_front_sel;
  assign frame_cnt = r_frame_cnt;
  assign clr_err   = r_clr_err;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_display_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_flip_ctrl
// Brief    : Self-checking bench for display_flip_ctrl. Frames are generated
//            as transactions (mid-frame requests, VBLANK, clear hold) and the
//            expected buffer/flag state is tracked per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_flip_ctrl;

  localparam logic [29:0] C_FB0 = 30'h1085557C;
  localparam logic [29:0] C_FB1 = 30'h10426240;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        VBLANK = 1'b0;
  logic        flip_req = 1'b0;
  logic        CLRVBLNK;
  logic [29:0] DISPADDR;
  logic        DISPON;
  logic        flip_ack;
  logic [29:0] back_addr;
  logic        front_sel;
  logic [15:0] frame_cnt;
  logic        clr_err;
  logic [2:0]  state;

  display_flip_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .VBLANK(VBLANK), .flip_req(flip_req),
    .CLRVBLNK(CLRVBLNK), .DISPADDR(DISPADDR), .DISPON(DISPON), .flip_ack(flip_ack),
    .back_addr(back_addr), .front_sel(front_sel), .frame_cnt(frame_cnt),
    .clr_err(clr_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected-state tracking
  bit          m_front;
  bit          m_pend;
  bit          m_on;
  logic [29:0] m_addr;
  logic [15:0] m_cnt;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] addr_of(input bit f);
    return f ? C_FB1 : C_FB0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input bit exp_ack, input bit exp_clr);
    chk({tag, "_addr"},  {2'b00, DISPADDR},  {2'b00, m_addr});
    chk({tag, "_on"},    {31'd0, DISPON},    {31'd0, m_on});
    chk({tag, "_sel"},   {31'd0, front_sel}, {31'd0, m_front});
    chk({tag, "_back"},  {2'b00, back_addr}, {2'b00, addr_of(~m_front)});
    chk({tag, "_ack"},   {31'd0, flip_ack},  {31'd0, exp_ack});
    chk({tag, "_cnt"},   {16'd0, frame_cnt}, {16'd0, m_cnt});
    chk({tag, "_err"},   {31'd0, clr_err},   {31'd0, m_err});
    chk({tag, "_clr"},   {31'd0, CLRVBLNK},  {31'd0, exp_clr});
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; VBLANK = 1'b0; flip_req = 1'b0;
    step();
    m_front = 1'b0; m_pend = 1'b0; m_on = 1'b0;
    m_addr = 30'd0; m_cnt = 16'd0; m_err = 1'b0;
    check_outputs("rst", 1'b0, 1'b1);
    chk("rst_state", {29'd0, state}, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rel_clr", {31'd0, CLRVBLNK}, 32'd0);
    chk("rel_state", {29'd0, state}, 32'd1);
  endtask

  task automatic do_swap(output bit ack);
    m_front = ~m_front;
    m_addr  = addr_of(m_front);
    m_pend  = 1'b0;
    ack     = 1'b1;
  endtask

  // One frame: mid-frame with nreq request pulses, VBLANK with the given
  // enable and optional coincident request, then a random clear hold.
  task automatic frame(input bit en, input int nreq, input bit coinc, input bit clr_reqs);
    int len;
    int hold;
    bit req;
    bit exp_ack;
    len = 2 * nreq + $urandom_range(6, 2);
    for (int i = 0; i < len; i++) begin
      flip_req = (i % 2 == 0) && (i / 2 < nreq);
      if (flip_req) m_pend = 1'b1;
      step();
      chk("mid_ack", {31'd0, flip_ack}, 32'd0);
      chk("mid_addr", {2'b00, DISPADDR}, {2'b00, m_addr});
    end
    VBLANK = 1'b1; enable = en; flip_req = coinc;
    req = m_pend | coinc;
    exp_ack = 1'b0;
    m_cnt = m_cnt + 16'd1;
    if (m_on) begin
      if (!en) begin
        m_on = 1'b0;
        m_pend = req;
      end else if (req) begin
        do_swap(exp_ack);
      end
    end else begin
      if (en) begin
        m_on = 1'b1;
        if (req) do_swap(exp_ack);
        else m_addr = addr_of(m_front);
      end else begin
        m_pend = req;
      end
    end
    step();
    flip_req = 1'b0;
    check_outputs("vb", exp_ack, 1'b1);
    chk("vb_state", {29'd0, state}, 32'd2);
    hold = $urandom_range(4, 0);
    for (int i = 0; i < hold; i++) begin
      flip_req = clr_reqs ? 1'($urandom_range(1, 0)) : 1'b0;
      if (flip_req) m_pend = 1'b1;
      step();
      check_outputs("hold", 1'b0, 1'b1);
    end
    VBLANK = 1'b0; flip_req = 1'b0;
    step();
    check_outputs("exit", 1'b0, 1'b0);
    chk("exit_state", {29'd0, state}, m_on ? 32'd3 : 32'd1);
  endtask

  task automatic timeout_test();
    int hi;
    VBLANK = 1'b1; enable = 1'b1; flip_req = 1'b0;
    m_cnt = m_cnt + 16'd1;
    step();
    chk("to_rise", {31'd0, CLRVBLNK}, 32'd1);
    hi = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (CLRVBLNK) hi++;
    end
    m_err = 1'b1;
    chk("to_len", hi, 32'd1023);
    check_outputs("to_end", 1'b0, 1'b0);
    chk("to_state", {29'd0, state}, 32'd3);
    VBLANK = 1'b0;
    step();
    step();
    check_outputs("to_drop", 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // bring-up, single flips, coincident, merged
    frame(1'b1, 0, 1'b0, 1'b0);
    frame(1'b1, 1, 1'b0, 1'b0);
    frame(1'b1, 1, 1'b0, 1'b0);
    frame(1'b1, 0, 1'b1, 1'b0);
    frame(1'b1, 3, 1'b0, 1'b0);
    frame(1'b1, 0, 1'b0, 1'b0);
    // disable with pending request, then re-enable
    frame(1'b0, 1, 1'b0, 1'b0);
    frame(1'b1, 0, 1'b0, 1'b0);
    frame(1'b0, 0, 1'b0, 1'b0);
    frame(1'b0, 1, 1'b0, 1'b0);
    frame(1'b1, 0, 1'b0, 1'b0);
    // request during clear applies to the following VBLANK
    frame(1'b1, 0, 1'b0, 1'b1);
    frame(1'b1, 0, 1'b0, 1'b0);
    for (int f = 0; f < 40; f++) begin
      frame($urandom_range(3, 0) != 0, $urandom_range(3, 0),
            1'($urandom_range(1, 0)), 1'b1);
    end
    frame(1'b1, 0, 1'b0, 1'b0);
    timeout_test();
    for (int f = 0; f < 20; f++) begin
      frame($urandom_range(3, 0) != 0, $urandom_range(3, 0),
            1'($urandom_range(1, 0)), 1'b1);
    end
    // reset while in the clear state
    frame(1'b1, 1, 1'b0, 1'b0);
    VBLANK = 1'b1; enable = 1'b1;
    step();
    chk("pre_rst_state", {29'd0, state}, 32'd2);
    do_reset();
    frame(1'b1, 0, 1'b0, 1'b0);
    frame(1'b1, 1, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_flip_ctrl.md
# display_flip_ctrl

Double-buffer flip scheduler for the display controller. It brings the display up on the first vertical blank and acknowledges every VBLANK through the CLRVBLNK handshake. On renderer request, it swaps DISPADDR between two frame buffers, only inside a blanking interval. It sits between the renderer (flip_req/flip_ack/back_addr) and the display IP register interface (VBLANK/CLRVBLNK/DISPADDR/DISPON).

## Interface
- FB0_ADDR, 30'h1085557C, word address of frame buffer 0 (front buffer after bring-up)
- FB1_ADDR, 30'h10426240, word address of frame buffer 1
- CLR_TIMEOUT, 16'd1023, max cycles CLRVBLNK is held waiting for VBLANK to drop
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- enable  in  1  1 = display should be on; sampled only at VBLANK
- VBLANK  in  1  sticky blank flag from display IP; cleared by CLRVBLNK
- flip_req  in  1  single-cycle request to swap buffers at next VBLANK
- CLRVBLNK  out  1  VBLANK clear request to display IP
- DISPADDR  out  30  current front-buffer address
- DISPON  out  1  display enable
- flip_ack  out  1  one-cycle pulse: swap performed
- back_addr  out  30  buffer the renderer may draw into (always the non-front buffer)
- front_sel  out  1  0 = FB0 displayed, 1 = FB1 displayed
- frame_cnt  out  16  VBLANKs serviced since reset, wraps FFFF→0000
- clr_err  out  1  sticky: a CLR timeout occurred; cleared only by reset
- state  out  3  FSM state encoding, for debug

## Operation
- Reset values: CLRVBLNK=1, DISPADDR=0, DISPON=0, flip_ack=0, front_sel=0, back_addr=FB1_ADDR, frame_cnt=0, clr_err=0, pending=0, state=S_RST.
- States (encoding): S_RST=0, S_WAIT=1, S_CLR=2, S_SHOW=3. Encodings 4–7 are illegal and go to S_RST next cycle.
- S_RST: CLRVBLNK←0 → S_WAIT.
- S_WAIT: if VBLANK=1 and enable=1: DISPADDR←FB0/FB1 per front_sel, DISPON←1, CLRVBLNK←1, frame_cnt+1 → S_CLR. If VBLANK=1 and enable=0: CLRVBLNK←1, frame_cnt+1 → S_CLR, display remains off. Otherwise hold.
- S_CLR: hold CLRVBLNK=1 and count cycles. When VBLANK=0: CLRVBLNK←0 → S_SHOW if DISPON=1, else S_WAIT. When the count reaches CLR_TIMEOUT: clr_err←1, CLRVBLNK←0, take the same exit.
- S_SHOW: on VBLANK=1: frame_cnt+1, CLRVBLNK←1 → S_CLR.
  - If enable=0 at that cycle: DISPON←0, no swap; pending is kept.
  - Else, if pending or flip_req (same cycle): front_sel toggles, DISPADDR←new front, back_addr←old front, flip_ack←1 for one cycle, pending←0.
- flip_req capture: in any state other than S_RST, a flip_req not consumed that cycle sets pending. A request while pending=1 merges (one swap, one ack). A request arriving during S_CLR applies at the next VBLANK, never the current one.
- back_addr always equals the buffer not in DISPADDR once DISPON=1. The renderer must not write the front buffer between flip_req and flip_ack.

## Timing
- Bring-up: rst released at cycle 0 → CLRVBLNK falls at cycle 1. DISPON/DISPADDR rise 1 cycle after first VBLANK=1 sample with enable=1.
- VBLANK sample → CLRVBLNK=1: 1 cycle. VBLANK low sample → CLRVBLNK=0: 1 cycle.
- Swap: DISPADDR, front_sel, back_addr and flip_ack all update in the same cycle, 1 cycle after the VBLANK sample.
- Minimum flip_req-to-ack latency: 1 cycle (request coincident with VBLANK in S_SHOW).
- Reset mid-operation (any state) takes effect next edge: all outputs return to reset values, CLRVBLNK=1 and the pending request is dropped.
- frame_cnt increments exactly once per VBLANK assertion, never while in S_CLR.

## Test plan
- Bring-up: release rst, enable=1, VBLANK high at cycle 10 → DISPADDR=30'h1085557C, DISPON=1, CLRVBLNK=1 at cycle 11; drop VBLANK at cycle 14 → CLRVBLNK=0 at cycle 15, frame_cnt=1.
- Flip: flip_req pulse mid-frame, next VBLANK → DISPADDR=30'h10426240, back_addr=30'h1085557C, front_sel=1, single flip_ack; second flip → back to FB0.
- Coincident/merged: flip_req on same cycle as VBLANK in S_SHOW → swap that VBLANK. Three flip_req pulses in one frame → exactly one swap and one ack.
- Timeout: hold VBLANK=1 for 2000 cycles after clear → CLRVBLNK falls after 1023 cycles, clr_err=1 and stays 1, frame_cnt increments once.
- Disable/reset: enable=0 with pending flip at VBLANK → DISPON=0, no swap, pending kept. Re-enable at next VBLANK → DISPON=1, swap, ack. Assert rst in S_CLR → CLRVBLNK=1, DISPON=0, DISPADDR=0, frame_cnt=0.
